jtkcpu_bus_target: RTL and testbench

- Responder end of the jtkcpu memory bus. The CPU drives addr/dout/we/as; this block returns din and dtack.
- Contains a small internal RAM with programmable wait states.
- Every address outside the RAM window is forwarded to an external req/ack port, which typically leads to SDRAM or ROM.
- A timeout guarantees that dtack always completes, so the CPU never hangs.

---
 rtl/jtkcpu_bus_target.sv | 223 ++++++++++++++++++++++
 tb/tb_jtkcpu_bus_target.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_bus_target.sv
// Responder for the jtkcpu memory bus: internal wait-stated RAM plus an external
// req/ack port with a timeout, so every CPU cycle is guaranteed to terminate.
module jtkcpu_bus_target #(
  parameter int unsigned RAM_AW   = 13,
  parameter logic [23:0] RAM_BASE = 24'h000000,
  parameter int unsigned WAIT     = 1,
  parameter int unsigned TOUT     = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cen_i,
  input  logic [23:0] addr_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        we_i,
  input  logic        as_i,
  output logic [7:0]  cpu_din_o,
  output logic        dtack_o,
  output logic [23:0] ext_addr_o,
  output logic [7:0]  ext_dout_o,
  output logic        ext_we_o,
  output logic        ext_req_o,
  input  logic        ext_ack_i,
  input  logic [7:0]  ext_din_i,
  output logic        bus_err_o
);

  localparam logic [3:0] WAIT_C = 4'(WAIT);
  localparam logic [7:0] TOUT_C = 8'(TOUT);

  typedef enum logic [1:0] {S_IDLE, S_IWAIT, S_EXT, S_ACK} state_e;

  state_e state_q, state_d;

  logic [RAM_AW-1:0] ram_idx_q, ram_idx_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        timer_q, timer_d;
  logic              aborted_q, aborted_d;
  logic [7:0]        cpu_din_q, cpu_din_d;
  logic              dtack_q, dtack_d;
  logic [23:0]       ext_addr_q, ext_addr_d;
  logic [7:0]        ext_dout_q, ext_dout_d;
  logic              ext_we_q, ext_we_d;
  logic              ext_req_q, ext_req_d;
  logic              bus_err_q, bus_err_d;
  logic              ram_we_s;
  logic [7:0]        ram_q [0:(1<<RAM_AW)-1];

  logic hit_s, tout_s, abort_s;
  assign hit_s   = (addr_i[23:RAM_AW] == RAM_BASE[23:RAM_AW]);
  assign tout_s  = (timer_q == TOUT_C);
  // An external cycle counts as abandoned once as has been seen low at any point.
  assign abort_s = aborted_q | ~as_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else if (cen_i) begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (as_i) state_d = hit_s ? S_IWAIT : S_EXT;
        else      state_d = S_IDLE;
      end
      S_IWAIT: begin
        if (!as_i)              state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_ACK;
        else                    state_d = S_IWAIT;
      end
      S_EXT: begin
        if (ext_ack_i || tout_s) state_d = abort_s ? S_IDLE : S_ACK;
        else                     state_d = S_EXT;
      end
      S_ACK: begin
        if (!as_i) state_d = S_IDLE;
        else       state_d = S_ACK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    ram_idx_d  = ram_idx_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    aborted_d  = aborted_q;
    cpu_din_d  = cpu_din_q;
    dtack_d    = dtack_q;
    ext_addr_d = ext_addr_q;
    ext_dout_d = ext_dout_q;
    ext_we_d   = ext_we_q;
    ext_req_d  = ext_req_q;
    bus_err_d  = 1'b0;
    ram_we_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (as_i) begin
          ram_idx_d = addr_i[RAM_AW-1:0];
          we_d      = we_i;
          wdata_d   = cpu_dout_i;
          if (hit_s) begin
            cnt_d = WAIT_C;
          end else begin
            ext_req_d  = 1'b1;
            ext_addr_d = addr_i;
            ext_dout_d = cpu_dout_i;
            ext_we_d   = we_i;
            timer_d    = 8'd0;
            aborted_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_IWAIT: begin
        if (!as_i) begin
          cnt_d = cnt_q;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          dtack_d = 1'b1;
          if (we_q) ram_we_s  = 1'b1;
          else      cpu_din_d = ram_q[ram_idx_q];
        end
      end
      S_EXT: begin
        if (ext_ack_i) begin
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          if (!abort_s) begin
            dtack_d = 1'b1;
            if (!we_q) cpu_din_d = ext_din_i;
            else       cpu_din_d = cpu_din_q;
          end else begin
            dtack_d = 1'b0;
          end
        end else if (tout_s) begin
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          bus_err_d = 1'b1;
          if (!abort_s) begin
            dtack_d = 1'b1;
            if (!we_q) cpu_din_d = 8'hFF;
            else       cpu_din_d = cpu_din_q;
          end else begin
            dtack_d = 1'b0;
          end
        end else begin
          timer_d   = timer_q + 8'd1;
          aborted_d = abort_s;
        end
      end
      S_ACK: begin
        if (!as_i) dtack_d = 1'b0;
        else       dtack_d = 1'b1;
      end
      default: begin
        dtack_d   = 1'b0;
        ext_req_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; all outputs come straight from here
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ram_idx_q  <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 8'd0;
      cnt_q      <= 4'd0;
      timer_q    <= 8'd0;
      aborted_q  <= 1'b0;
      cpu_din_q  <= 8'd0;
      dtack_q    <= 1'b0;
      ext_addr_q <= 24'd0;
      ext_dout_q <= 8'd0;
      ext_we_q   <= 1'b0;
      ext_req_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else if (cen_i) begin
      ram_idx_q  <= ram_idx_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      aborted_q  <= aborted_d;
      cpu_din_q  <= cpu_din_d;
      dtack_q    <= dtack_d;
      ext_addr_q <= ext_addr_d;
      ext_dout_q <= ext_dout_d;
      ext_we_q   <= ext_we_d;
      ext_req_q  <= ext_req_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (cen_i && ram_we_s) begin
      ram_q[ram_idx_q] <= wdata_q;
    end
  end

  assign cpu_din_o  = cpu_din_q;
  assign dtack_o    = dtack_q;
  assign ext_addr_o = ext_addr_q;
  assign ext_dout_o = ext_dout_q;
  assign ext_we_o   = ext_we_q;
  assign ext_req_o  = ext_req_q;
  assign bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_jtkcpu_bus_target.sv
// Bench for jtkcpu_bus_target: two instances (WAIT=1/TOUT=4 and WAIT=3/TOUT=255)
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_jtkcpu_bus_target;

  localparam int P_IDLE = 0, P_RAM = 1, P_EXT = 2, P_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen_s     [2];
  logic        we_s      [2];
  logic        as_s      [2];
  logic        ext_ack_s [2];
  logic [23:0] addr_s    [2];
  logic [7:0]  dout_s    [2];
  logic [7:0]  ext_din_s [2];
  logic [7:0]  cpu_din_s [2];
  logic        dtack_s   [2];
  logic [23:0] ext_addr_s[2];
  logic [7:0]  ext_dout_s[2];
  logic        ext_we_s  [2];
  logic        ext_req_s [2];
  logic        bus_err_s [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jtkcpu_bus_target #(.RAM_AW(13), .RAM_BASE(24'h000000), .WAIT(1), .TOUT(4)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .cen_i(cen_s[0]), .addr_i(addr_s[0]),
    .cpu_dout_i(dout_s[0]), .we_i(we_s[0]), .as_i(as_s[0]), .cpu_din_o(cpu_din_s[0]),
    .dtack_o(dtack_s[0]), .ext_addr_o(ext_addr_s[0]), .ext_dout_o(ext_dout_s[0]),
    .ext_we_o(ext_we_s[0]), .ext_req_o(ext_req_s[0]), .ext_ack_i(ext_ack_s[0]),
    .ext_din_i(ext_din_s[0]), .bus_err_o(bus_err_s[0]));

  jtkcpu_bus_target #(.RAM_AW(13), .RAM_BASE(24'h000000), .WAIT(3), .TOUT(255)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .cen_i(cen_s[1]), .addr_i(addr_s[1]),
    .cpu_dout_i(dout_s[1]), .we_i(we_s[1]), .as_i(as_s[1]), .cpu_din_o(cpu_din_s[1]),
    .dtack_o(dtack_s[1]), .ext_addr_o(ext_addr_s[1]), .ext_dout_o(ext_dout_s[1]),
    .ext_we_o(ext_we_s[1]), .ext_req_o(ext_req_s[1]), .ext_ack_i(ext_ack_s[1]),
    .ext_din_i(ext_din_s[1]), .bus_err_o(bus_err_s[1]));

  function automatic int wt(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int to(int k);
    return (k == 0) ? 4 : 255;
  endfunction

  // Model: phase of the current CPU cycle plus cen edges elapsed since it was accepted
  int          m_ph   [2] = '{P_IDLE, P_IDLE};
  int          m_n    [2] = '{0, 0};
  logic        m_ab   [2] = '{1'b0, 1'b0};
  logic        m_lwe  [2] = '{1'b0, 1'b0};
  logic [12:0] m_idx  [2] = '{13'd0, 13'd0};
  logic [7:0]  m_wd   [2] = '{8'd0, 8'd0};
  logic        m_dt   [2] = '{1'b0, 1'b0};
  logic        m_req  [2] = '{1'b0, 1'b0};
  logic        m_ewe  [2] = '{1'b0, 1'b0};
  logic        m_err  [2] = '{1'b0, 1'b0};
  logic [7:0]  m_din  [2] = '{8'd0, 8'd0};
  logic [7:0]  m_edout[2] = '{8'd0, 8'd0};
  logic [23:0] m_eaddr[2] = '{24'd0, 24'd0};
  logic [7:0]  m_mem  [2][8192];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst_n !== 1'b1) begin
        m_ph[k] = P_IDLE; m_n[k] = 0; m_ab[k] = 1'b0; m_dt[k] = 1'b0; m_din[k] = 8'd0;
        m_req[k] = 1'b0; m_ewe[k] = 1'b0; m_eaddr[k] = 24'd0; m_edout[k] = 8'd0; m_err[k] = 1'b0;
      end else if (cen_s[k]) begin
        m_err[k] = 1'b0;
        case (m_ph[k])
          P_IDLE: if (as_s[k]) begin
            m_idx[k] = addr_s[k][12:0]; m_lwe[k] = we_s[k]; m_wd[k] = dout_s[k];
            m_n[k] = 0; m_ab[k] = 1'b0;
            if (addr_s[k][23:13] == 11'd0) m_ph[k] = P_RAM;
            else begin
              m_ph[k] = P_EXT; m_req[k] = 1'b1; m_eaddr[k] = addr_s[k];
              m_edout[k] = dout_s[k]; m_ewe[k] = we_s[k];
            end
          end
          P_RAM: if (!as_s[k]) m_ph[k] = P_IDLE;
          else begin
            m_n[k]++;
            if (m_n[k] == wt(k) + 1) begin
              if (m_lwe[k]) m_mem[k][m_idx[k]] = m_wd[k];
              else m_din[k] = m_mem[k][m_idx[k]];
              m_dt[k] = 1'b1; m_ph[k] = P_HOLD;
            end
          end
          P_EXT: begin
            m_n[k]++;
            if (!as_s[k]) m_ab[k] = 1'b1;
            if (ext_ack_s[k] || m_n[k] == to(k) + 1) begin
              m_req[k] = 1'b0; m_ewe[k] = 1'b0;
              m_err[k] = !ext_ack_s[k];
              if (m_ab[k]) m_ph[k] = P_IDLE;
              else begin
                m_dt[k] = 1'b1; m_ph[k] = P_HOLD;
                if (!m_lwe[k]) m_din[k] = ext_ack_s[k] ? ext_din_s[k] : 8'hFF;
              end
            end
          end
          P_HOLD: if (!as_s[k]) begin m_dt[k] = 1'b0; m_ph[k] = P_IDLE; end
          default: m_ph[k] = P_IDLE;
        endcase
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({dtack_s[k], cpu_din_s[k], ext_req_s[k], ext_addr_s[k], ext_dout_s[k], ext_we_s[k], bus_err_s[k]}
          !== {m_dt[k], m_din[k], m_req[k], m_eaddr[k], m_edout[k], m_ewe[k], m_err[k]}) begin
        n_bad++;
        $display("FAIL model_cmp inst%0d t=%0t got dt=%b din=%h req=%b ea=%h ed=%h we=%b err=%b exp dt=%b din=%h req=%b ea=%h ed=%h we=%b err=%b",
                 k, $time, dtack_s[k], cpu_din_s[k], ext_req_s[k], ext_addr_s[k], ext_dout_s[k], ext_we_s[k], bus_err_s[k],
                 m_dt[k], m_din[k], m_req[k], m_eaddr[k], m_edout[k], m_ewe[k], m_err[k]);
      end
    end
  end

  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic start(int k, logic [23:0] a, logic [7:0] d, logic w);
    @(negedge clk);
    addr_s[k] = a; dout_s[k] = d; we_s[k] = w; as_s[k] = 1'b1;
  endtask

  // Edges are counted from the negedge after the request is driven; latency = edges-1
  task automatic wait_dtack(int k, int maxc, output int edges);
    edges = 0;
    do begin @(negedge clk); edges++; end while (dtack_s[k] !== 1'b1 && edges < maxc);
    if (dtack_s[k] !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL dtack_timeout inst%0d got=0 exp=1", k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int e, errs, dts, reqs, first;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cen_s[k] = 1'b1; we_s[k] = 1'b0; as_s[k] = 1'b0; ext_ack_s[k] = 1'b0;
      addr_s[k] = 24'd0; dout_s[k] = 8'd0; ext_din_s[k] = 8'd0;
    end
    repeat (2) @(negedge clk);
    check("rst_dtack", dtack_s[0], 0);
    check("rst_req", ext_req_s[1], 0);
    check("rst_din", cpu_din_s[0], 0);
    rst_n = 1'b1;

    // RAM write then read, WAIT=1
    start(0, 24'h000010, 8'h5A, 1'b1);
    wait_dtack(0, 20, e); check("t1_wr_lat", e - 1, 2);
    as_s[0] = 1'b0;
    start(0, 24'h000010, 8'h00, 1'b0);
    wait_dtack(0, 20, e); check("t1_rd_lat", e - 1, 2);
    check("t1_rd_data", cpu_din_s[0], 8'h5A);
    as_s[0] = 1'b0;

    // External read, ack sampled 5 cen edges after ext_req rises
    start(1, 24'h800000, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    check("t2_req", ext_req_s[1], 1);
    check("t2_addr", ext_addr_s[1], 24'h800000);
    check("t2_we", ext_we_s[1], 0);
    ext_din_s[1] = 8'hC3; ext_ack_s[1] = 1'b1;
    @(negedge clk);
    check("t2_dtack", dtack_s[1], 1);
    check("t2_din", cpu_din_s[1], 8'hC3);
    check("t2_req_fall", ext_req_s[1], 0);
    ext_ack_s[1] = 1'b0; as_s[1] = 1'b0;

    // Timeout, TOUT=4: fires on the 5th cen edge after entry
    start(0, 24'h900000, 8'h00, 1'b0);
    errs = 0; first = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus_err_s[0]) errs++;
      if (dtack_s[0] && first < 0) first = i;
    end
    check("t3_first_dtack", first, 6);
    check("t3_err_pulses", errs, 1);
    check("t3_din", cpu_din_s[0], 8'hFF);
    check("t3_dtack_held", dtack_s[0], 1);
    check("t3_req", ext_req_s[0], 0);
    as_s[0] = 1'b0;
    @(negedge clk);
    check("t3_dtack_drop", dtack_s[0], 0);

    // Ack coinciding with the timeout edge: ack wins, write leaves cpu_din alone
    start(0, 24'hA00000, 8'h77, 1'b1);
    repeat (5) @(negedge clk);
    ext_din_s[0] = 8'h11; ext_ack_s[0] = 1'b1;
    @(negedge clk);
    check("t3b_dtack", dtack_s[0], 1);
    check("t3b_no_err", bus_err_s[0], 0);
    check("t3b_din", cpu_din_s[0], 8'hFF);
    ext_ack_s[0] = 1'b0; as_s[0] = 1'b0;

    // WAIT=3 write with a 3-cycle cen stall, then an aborted write
    start(1, 24'h000020, 8'hA5, 1'b1);
    @(negedge clk); cen_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    cen_s[1] = 1'b1;
    wait_dtack(1, 20, e); check("t4_stall_lat", e, 4);
    as_s[1] = 1'b0;
    start(1, 24'h000020, 8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    as_s[1] = 1'b0;
    dts = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (dtack_s[1]) dts++; end
    check("t4_abort_no_dtack", dts, 0);
    start(1, 24'h000020, 8'h00, 1'b0);
    wait_dtack(1, 20, e); check("t4_rd_lat", e - 1, 4);
    check("t4_ram_kept", cpu_din_s[1], 8'hA5);
    as_s[1] = 1'b0;

    // External read abandoned mid-cycle: req holds until ack, no dtack
    start(1, 24'h400000, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    as_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("t4b_req_held", ext_req_s[1], 1);
    ext_din_s[1] = 8'h5E; ext_ack_s[1] = 1'b1;
    dts = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); ext_ack_s[1] = 1'b0;
      if (dtack_s[1]) dts++;
    end
    check("t4b_no_dtack", dts, 0);
    check("t4b_req_low", ext_req_s[1], 0);
    check("t4b_din_kept", cpu_din_s[1], 8'hA5);

    // Abandoned external read that times out still pulses bus_err
    start(0, 24'hB00000, 8'h00, 1'b0);
    @(negedge clk); as_s[0] = 1'b0;
    errs = 0; dts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_err_s[0]) errs++;
      if (dtack_s[0]) dts++;
    end
    check("t4c_err", errs, 1);
    check("t4c_no_dtack", dts, 0);

    // as held after ACK: no re-trigger; one low cycle starts a new access
    start(0, 24'hC00000, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    ext_din_s[0] = 8'h99; ext_ack_s[0] = 1'b1;
    @(negedge clk);
    ext_ack_s[0] = 1'b0;
    check("t5_dtack", dtack_s[0], 1);
    check("t5_din", cpu_din_s[0], 8'h99);
    reqs = 0; dts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ext_req_s[0]) reqs++;
      if (!dtack_s[0]) dts++;
    end
    check("t5_no_retrigger", reqs, 0);
    check("t5_dtack_held", dts, 0);
    as_s[0] = 1'b0;
    @(negedge clk); as_s[0] = 1'b1;
    @(negedge clk);
    check("t5_second_req", ext_req_s[0], 1);
    ext_din_s[0] = 8'h66; ext_ack_s[0] = 1'b1;
    @(negedge clk);
    check("t5_second_dtack", dtack_s[0], 1);
    check("t5_second_din", cpu_din_s[0], 8'h66);
    ext_ack_s[0] = 1'b0; as_s[0] = 1'b0;

    // Asynchronous reset with inst0 in ACK and inst1 in EXT
    start(0, 24'h000010, 8'h00, 1'b0);
    wait_dtack(0, 20, e);
    start(1, 24'h700000, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req_async", ext_req_s[1], 0);
    check("t6_dtack_async", dtack_s[0], 0);
    check("t6_din_async", cpu_din_s[0], 0);
    as_s[0] = 1'b0; as_s[1] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    start(1, 24'h000020, 8'h00, 1'b0);
    wait_dtack(1, 20, e); check("t6_post_lat", e - 1, 4);
    check("t6_ram_survives", cpu_din_s[1], 8'hA5);
    as_s[1] = 1'b0;

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
